// File: rtl/harvard_bridge_pkg.sv
// Shared types and constants for the Harvard core to Avalon-MM bridge.
package harvard_bridge_pkg;

    // Bridge sequencer states, one instruction walks FETCH -> DECODE -> [DREAD|DWRITE] -> COMMIT
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_DREAD  = 3'd3,
        ST_DWRITE = 3'd4,
        ST_COMMIT = 3'd5,
        ST_HALT   = 3'd6
    } bridge_state_t;

    // Clears the byte-offset bits so every bus access is word aligned.
    // Wide enough for any address width up to 64 bits; users slice it down.
    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/avm_wait_timer.sv
// Counts consecutive waitrequest cycles of a pending bus request and flags
// the cycle on which the limit is reached.
module avm_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic waitrequest,
    output logic expired
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(TIMEOUT_CYCLES - 1);

    logic [CNT_BITS-1:0] count_reg;
    logic [CNT_BITS-1:0] count_next;

    // Count while stalled; any non-bus state or accepted transfer restarts from zero
    always_comb begin
        count_next = '0;
        if (busy && waitrequest) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = busy && waitrequest && (count_reg == LAST_COUNT);

endmodule

// File: rtl/harvard_avalon_bridge.sv
// Sequences a Harvard core's instruction fetch and data access onto one
// Avalon-MM master port and strobes the core forward once per instruction.
// Optional feature macro: BRIDGE_TIMEOUT_EN (abort stalled transfers into HALT
// with a sticky bus_error).
module harvard_avalon_bridge
    import harvard_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    // core side
    input  logic [ADDR_W-1:0]   instr_address,
    output logic [DATA_W-1:0]   instr_readdata,
    input  logic [ADDR_W-1:0]   data_address,
    input  logic                data_read,
    input  logic                data_write,
    input  logic [DATA_W-1:0]   data_writedata,
    input  logic [DATA_W/8-1:0] data_byteenable,
    output logic [DATA_W-1:0]   data_readdata,
    input  logic                cpu_active,
    output logic                cpu_clk_enable,
    // Avalon-MM master
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    // status
    output logic [CNT_W-1:0]    commit_count,
    output logic                halted,
    output logic                bus_error
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = WORD_ALIGN_MASK[ADDR_W-1:0];

    bridge_state_t     state_reg;
    bridge_state_t     state_next;
    logic [DATA_W-1:0] instr_readdata_reg;
    logic [DATA_W-1:0] data_readdata_reg;
    logic [CNT_W-1:0]  commit_count_reg;
    logic              bus_busy;
    logic              timeout;

    assign bus_busy = (state_reg == ST_FETCH) || (state_reg == ST_DREAD) ||
                      (state_reg == ST_DWRITE);

`ifdef BRIDGE_TIMEOUT_EN
    logic bus_error_reg;

    avm_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk         (clk),
        .reset       (reset),
        .busy        (bus_busy),
        .waitrequest (avm_waitrequest),
        .expired     (timeout)
    );

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_error_reg <= 1'b0;
        end else if (timeout) begin
            bus_error_reg <= 1'b1;
        end
    end

    assign bus_error = bus_error_reg;
`else
    // Stalls wait forever; the limit parameter has no effect in this build
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYCLES == 0) && bus_busy;
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    // Next-state selection and state-decoded bus/core outputs
    always_comb begin
        state_next     = state_reg;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_byteenable = '0;
        cpu_clk_enable = 1'b0;
        halted         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                avm_read       = 1'b1;
                avm_address    = instr_address & ALIGN_MASK;
                avm_byteenable = '1;
                if (timeout) begin
                    state_next = ST_HALT;
                end else if (!avm_waitrequest) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Store takes priority if the core raises both strobes
                if (data_write) begin
                    state_next = ST_DWRITE;
                end else if (data_read) begin
                    state_next = ST_DREAD;
                end else begin
                    state_next = ST_COMMIT;
                end
            end
            ST_DREAD: begin
                avm_read       = 1'b1;
                avm_address    = data_address & ALIGN_MASK;
                avm_byteenable = '1;
                if (timeout) begin
                    state_next = ST_HALT;
                end else if (!avm_waitrequest) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_DWRITE: begin
                avm_write      = 1'b1;
                avm_address    = data_address & ALIGN_MASK;
                avm_writedata  = data_writedata;
                avm_byteenable = data_byteenable;
                if (timeout) begin
                    state_next = ST_HALT;
                end else if (!avm_waitrequest) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                cpu_clk_enable = 1'b1;
                state_next     = cpu_active ? ST_FETCH : ST_HALT;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, latched read data and commit counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg          <= ST_IDLE;
            instr_readdata_reg <= '0;
            data_readdata_reg  <= '0;
            commit_count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_FETCH && !avm_waitrequest) begin
                instr_readdata_reg <= avm_readdata;
            end
            if (state_reg == ST_DREAD && !avm_waitrequest) begin
                data_readdata_reg <= avm_readdata;
            end
            if (state_reg == ST_COMMIT) begin
                commit_count_reg <= commit_count_reg + 1'b1;
            end
        end
    end

    assign instr_readdata = instr_readdata_reg;
    assign data_readdata  = data_readdata_reg;
    assign commit_count   = commit_count_reg;

endmodule

// File: tb/tb_harvard_avalon_bridge.sv
// Directed bench for harvard_avalon_bridge. Inputs change and outputs are
// observed on the falling edge; the DUT acts on the rising edge.
module tb_harvard_avalon_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_readdata;
    logic [31:0] data_address = '0;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_writedata = '0;
    logic [3:0]  data_byteenable = '0;
    logic [31:0] data_readdata;
    logic        cpu_active = 1'b0;
    logic        cpu_clk_enable;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] commit_count;
    logic        halted;
    logic        bus_error;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    harvard_avalon_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_address    (data_address),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .cpu_active      (cpu_active),
        .cpu_clk_enable  (cpu_clk_enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .commit_count    (commit_count),
        .halted          (halted),
        .bus_error       (bus_error)
    );

    // Advance one clock and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for two edges with quiet inputs; leaves reset asserted
    task automatic do_reset();
        reset           = 1'b0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = '0;
        data_writedata  = '0;
        data_byteenable = '0;
        avm_waitrequest = 1'b0;
        avm_readdata    = '0;
        cpu_active      = 1'b1;
        instr_address   = 32'h0040_0000;
        step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL reset_avm_read got %b want 0", avm_read); end
        n_cmp++; if (avm_write !== 1'b0) begin n_err++; $display("FAIL reset_avm_write got %b want 0", avm_write); end
        n_cmp++; if (cpu_clk_enable !== 1'b0) begin n_err++; $display("FAIL reset_clk_en got %b want 0", cpu_clk_enable); end
        n_cmp++; if (instr_readdata !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr_readdata); end
        n_cmp++; if (data_readdata !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_readdata); end
        n_cmp++; if (commit_count !== 32'h0) begin n_err++; $display("FAIL reset_count got %0d want 0", commit_count); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL reset_bus_error got %b want 0", bus_error); end
        $display("reset: outputs cleared, count=%0d", commit_count);
    endtask

    task automatic test_alu();
        do_reset();
        instr_address = 32'h0040_0002;
        avm_readdata  = 32'h0085_1020;
        reset         = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_cmp++;
            if (cpu_clk_enable !== (i % 3 == 0)) begin
                n_err++; $display("FAIL alu_clk_en cycle %0d got %b want %b", i, cpu_clk_enable, (i % 3 == 0));
            end
            if (i == 1) begin
                n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL alu_fetch_read got %b want 1", avm_read); end
                n_cmp++; if (avm_address !== 32'h0040_0000) begin n_err++; $display("FAIL alu_fetch_addr got %h want 00400000", avm_address); end
                n_cmp++; if (avm_byteenable !== 4'hF) begin n_err++; $display("FAIL alu_fetch_be got %b want 1111", avm_byteenable); end
            end
            if (i == 2) begin
                n_cmp++; if (instr_readdata !== 32'h0085_1020) begin n_err++; $display("FAIL alu_instr got %h want 00851020", instr_readdata); end
                n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL alu_decode_read got %b want 0", avm_read); end
            end
            if (i == 4) begin
                n_cmp++; if (commit_count !== 32'd1) begin n_err++; $display("FAIL alu_count1 got %0d want 1", commit_count); end
            end
            if (cpu_clk_enable) $display("alu: commit at cycle %0d", i);
        end
        step();
        n_cmp++; if (commit_count !== 32'd3) begin n_err++; $display("FAIL alu_count3 got %0d want 3", commit_count); end
    endtask

    task automatic test_load();
        do_reset();
        instr_address = 32'h0040_0010;
        avm_readdata  = 32'h8C82_0000;
        data_read     = 1'b1;
        data_address  = 32'h0000_1003;
        reset         = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++;
            if (cpu_clk_enable !== (i == 6)) begin
                n_err++; $display("FAIL load_clk_en cycle %0d got %b want %b", i, cpu_clk_enable, (i == 6));
            end
            if (i >= 3 && i <= 5) begin
                n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL load_read cycle %0d got %b want 1", i, avm_read); end
                n_cmp++; if (avm_address !== 32'h0000_1000) begin n_err++; $display("FAIL load_addr cycle %0d got %h want 00001000", i, avm_address); end
            end
            if (i == 4) begin
                n_cmp++; if (data_readdata !== 32'h0) begin n_err++; $display("FAIL load_early_latch got %h want 0", data_readdata); end
            end
            if (i == 6) begin
                n_cmp++; if (data_readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_data got %h want deadbeef", data_readdata); end
                $display("load: addr 1003 -> data %h committed at cycle %0d", data_readdata, i);
            end
            // bus responses for the rising edge that ends cycle i
            avm_waitrequest = (i == 3 || i == 4);
            avm_readdata    = (i == 5) ? 32'hDEAD_BEEF : 32'h1234_5678;
        end
        step();
        n_cmp++; if (commit_count !== 32'd1) begin n_err++; $display("FAIL load_count got %0d want 1", commit_count); end
        data_read = 1'b0;
    endtask

    task automatic test_store();
        int writes;
        writes = 0;
        do_reset();
        avm_readdata    = 32'hA482_0000;
        data_write      = 1'b1;
        data_read       = 1'b1;
        data_address    = 32'h0000_2002;
        data_byteenable = 4'b0011;
        data_writedata  = 32'h0000_BEEF;
        reset           = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (avm_write) writes++;
            n_cmp++;
            if ((avm_read && avm_write) !== 1'b0) begin
                n_err++; $display("FAIL store_rw_overlap cycle %0d read %b write %b", i, avm_read, avm_write);
            end
            if (i == 3) begin
                n_cmp++; if (avm_write !== 1'b1) begin n_err++; $display("FAIL store_write got %b want 1", avm_write); end
                n_cmp++; if (avm_byteenable !== 4'b0011) begin n_err++; $display("FAIL store_be got %b want 0011", avm_byteenable); end
                n_cmp++; if (avm_writedata !== 32'h0000_BEEF) begin n_err++; $display("FAIL store_wdata got %h want 0000beef", avm_writedata); end
                n_cmp++; if (avm_address !== 32'h0000_2000) begin n_err++; $display("FAIL store_addr got %h want 00002000", avm_address); end
            end
            if (i == 4) begin
                n_cmp++; if (cpu_clk_enable !== 1'b1) begin n_err++; $display("FAIL store_commit got %b want 1", cpu_clk_enable); end
                $display("store: be %b data %h committed at cycle %0d", data_byteenable, data_writedata, i);
            end
            if (i == 4) begin
                data_write = 1'b0;
                data_read  = 1'b0;
            end
        end
        n_cmp++; if (writes !== 1) begin n_err++; $display("FAIL store_write_cycles got %0d want 1", writes); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_address = 32'h0040_0021;
        avm_readdata  = 32'h8C82_0004;
        data_read     = 1'b1;
        data_address  = 32'h0000_1003;
        reset         = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            avm_waitrequest = (i >= 3);
        end
        n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL midrst_pre_read got %b want 1", avm_read); end
        reset = 1'b0;
        step();
        n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL midrst_read got %b want 0", avm_read); end
        n_cmp++; if (commit_count !== 32'h0) begin n_err++; $display("FAIL midrst_count got %0d want 0", commit_count); end
        n_cmp++; if (data_readdata !== 32'h0) begin n_err++; $display("FAIL midrst_data got %h want 0", data_readdata); end
        reset           = 1'b1;
        avm_waitrequest = 1'b0;
        data_read       = 1'b0;
        step();
        n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL midrst_refetch got %b want 1", avm_read); end
        n_cmp++; if (avm_address !== 32'h0040_0020) begin n_err++; $display("FAIL midrst_refetch_addr got %h want 00400020", avm_address); end
        $display("reset_mid: load abandoned, refetch at %h", avm_address);
    endtask

    task automatic test_halt();
        int reads;
        reads = 0;
        do_reset();
        cpu_active = 1'b0;
        reset      = 1'b1;
        for (int i = 1; i <= 3; i++) step();
        n_cmp++; if (cpu_clk_enable !== 1'b1) begin n_err++; $display("FAIL halt_commit got %b want 1", cpu_clk_enable); end
        step();
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag got %b want 1", halted); end
        for (int i = 0; i < 50; i++) begin
            step();
            if (avm_read || avm_write || cpu_clk_enable) reads++;
        end
        n_cmp++; if (reads !== 0) begin n_err++; $display("FAIL halt_bus_activity got %0d want 0", reads); end
        n_cmp++; if (commit_count !== 32'd1) begin n_err++; $display("FAIL halt_count got %0d want 1", commit_count); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_hold got %b want 1", halted); end
        $display("halt: halted=%b after 50 idle cycles", halted);
    endtask

    task automatic test_stuck_wait();
        int commits;
        commits = 0;
        do_reset();
        avm_waitrequest = 1'b1;
        reset           = 1'b1;
`ifdef BRIDGE_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) step();
        n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL tmo_read8 got %b want 1", avm_read); end
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL tmo_early_err got %b want 0", bus_error); end
        step();
        n_cmp++; if (bus_error !== 1'b1) begin n_err++; $display("FAIL tmo_bus_error got %b want 1", bus_error); end
        n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL tmo_halted got %b want 1", halted); end
        n_cmp++; if (avm_read !== 1'b0) begin n_err++; $display("FAIL tmo_read_drop got %b want 0", avm_read); end
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_clk_enable) commits++;
        end
        n_cmp++; if (commits !== 0) begin n_err++; $display("FAIL tmo_commits got %0d want 0", commits); end
        n_cmp++; if (commit_count !== 32'h0) begin n_err++; $display("FAIL tmo_count got %0d want 0", commit_count); end
        n_cmp++; if (bus_error !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got %b want 1", bus_error); end
        $display("timeout: bus_error=%b halted=%b", bus_error, halted);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_clk_enable) commits++;
        end
        n_cmp++; if (avm_read !== 1'b1) begin n_err++; $display("FAIL stuck_read got %b want 1", avm_read); end
        n_cmp++; if (bus_error !== 1'b0) begin n_err++; $display("FAIL stuck_bus_error got %b want 0", bus_error); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL stuck_halted got %b want 0", halted); end
        n_cmp++; if (commits !== 0) begin n_err++; $display("FAIL stuck_commits got %0d want 0", commits); end
        $display("stuck: still waiting, avm_read=%b", avm_read);
`endif
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_reset_mid();
        test_halt();
        test_stuck_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
